// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bus arbiter: FSM state encoding and index-width helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_HANDOVER,
    S_ARB_OWNED,
    S_ARB_RELEASE
  } sram_arb_state_type;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned sram_arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_picker.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting from ptr_i. Requests must already exclude the default client.
module sram_arb_picker
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned RR_MODE     = 0,
  localparam int unsigned IDX_W      = sram_arb_idx_w(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   valid_o,
  output logic [NUM_CLIENTS-1:0] onehot_o,
  output logic [IDX_W-1:0]       idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = (RR_MODE != 0) ? ((32'(ptr_i) + k) % NUM_CLIENTS) : k;
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// SRAM bus owner: default client holds the bus when idle, others request/release it.
// Optional ownership watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned DEFAULT_CLIENT = 0,
  parameter int unsigned RR_MODE        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  localparam int unsigned IDX_W         = sram_arb_idx_w(NUM_CLIENTS)
) (
  input  logic                          CLOCK_50_I,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        done,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_write_data,
  input  logic [NUM_CLIENTS-1:0]        client_we_n,
  output logic [NUM_CLIENTS-1:0]        grant,
  output logic [IDX_W-1:0]              owner,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  output logic                          busy,
  output logic                          timeout_flag
);

  localparam logic [NUM_CLIENTS-1:0] DEF_MASK = NUM_CLIENTS'(1) << DEFAULT_CLIENT;
  localparam logic [IDX_W-1:0]       DEF_IDX  = IDX_W'(DEFAULT_CLIENT);

  sram_arb_state_type       state_q;
  logic [NUM_CLIENTS-1:0]   grant_q;
  logic [NUM_CLIENTS-1:0]   win_q;
  logic [IDX_W-1:0]         owner_q;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic                     busy_q;

  logic                     pick_valid;
  logic [NUM_CLIENTS-1:0]   pick_onehot;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         ptr_next;
  logic                     we_sel;
  logic                     done_sel;
  logic                     wd_expire;

  sram_arb_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .RR_MODE     (RR_MODE)
  ) u_picker (
    .req_i    (req & ~DEF_MASK),
    .ptr_i    (rr_ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    ptr_next = (pick_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Bus mux follows the registered owner; turnaround states suppress writes.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    we_sel          = 1'b1;
    done_sel        = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (owner_q == IDX_W'(i)) begin
        SRAM_address    = client_address[i*ADDR_W +: ADDR_W];
        SRAM_write_data = client_write_data[i*DATA_W +: DATA_W];
        we_sel          = client_we_n[i];
        done_sel        = done[i];
      end
    end
    SRAM_we_n = (state_q == S_ARB_HANDOVER || state_q == S_ARB_RELEASE) ? 1'b1 : we_sel;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q  <= S_ARB_IDLE;
      grant_q  <= '0;
      win_q    <= '0;
      owner_q  <= DEF_IDX;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ARB_IDLE: begin
          if (pick_valid) begin
            state_q  <= S_ARB_HANDOVER;
            owner_q  <= pick_idx;
            win_q    <= pick_onehot;
            rr_ptr_q <= ptr_next;
            busy_q   <= 1'b1;
          end
        end
        S_ARB_HANDOVER: begin
          state_q <= S_ARB_OWNED;
          grant_q <= win_q;
        end
        S_ARB_OWNED: begin
          if (done_sel || wd_expire) begin
            state_q <= S_ARB_RELEASE;
            grant_q <= '0;
            owner_q <= DEF_IDX;
          end
        end
        S_ARB_RELEASE: begin
          state_q <= S_ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_ARB_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = sram_arb_idx_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [ADDR_W-1:0] wd_addr_q;
  logic              tflag_q;

  assign wd_expire = (state_q == S_ARB_OWNED) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Any owner write or address movement counts as activity and restarts the count.
  always_comb begin
    wd_cnt_d = wd_cnt_q + 1'b1;
    if (!SRAM_we_n || SRAM_address != wd_addr_q) wd_cnt_d = '0;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      wd_addr_q <= '0;
      tflag_q   <= 1'b0;
    end else begin
      wd_addr_q <= SRAM_address;
      if (state_q == S_ARB_HANDOVER) begin
        wd_cnt_q <= '0;
        tflag_q  <= 1'b0;
      end else if (state_q == S_ARB_OWNED) begin
        wd_cnt_q <= wd_cnt_d;
        if (wd_expire) tflag_q <= 1'b1;
      end
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign wd_expire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against an ownership-level reference model.
module tb_sram_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  req, done, we_n;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;

  logic [N-1:0]  grant_f, grant_r;
  logic [1:0]    owner_f, owner_r;
  logic [AW-1:0] addr_f, addr_r;
  logic [DW-1:0] data_f, data_r;
  logic          wen_f, wen_r, busy_f, busy_r, tf_f, tf_r;

  sram_access_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .DEFAULT_CLIENT(0),
    .RR_MODE(0), .TIMEOUT_CYCLES(TO)
  ) dut_fp (
    .CLOCK_50_I(clk), .reset(reset), .req(req), .done(done),
    .client_address(addr), .client_write_data(wdata), .client_we_n(we_n),
    .grant(grant_f), .owner(owner_f), .SRAM_address(addr_f),
    .SRAM_write_data(data_f), .SRAM_we_n(wen_f), .busy(busy_f),
    .timeout_flag(tf_f)
  );

  sram_access_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .DEFAULT_CLIENT(0),
    .RR_MODE(1), .TIMEOUT_CYCLES(TO)
  ) dut_rr (
    .CLOCK_50_I(clk), .reset(reset), .req(req), .done(done),
    .client_address(addr), .client_write_data(wdata), .client_we_n(we_n),
    .grant(grant_r), .owner(owner_r), .SRAM_address(addr_r),
    .SRAM_write_data(data_r), .SRAM_we_n(wen_r), .busy(busy_r),
    .timeout_flag(tf_r)
  );

  // Model per instance (0 = fixed, 1 = round-robin): granted owner, pending
  // winner waiting out the handover, release cooldown, search start, idle run.
  int            m_own[2], m_pend[2], m_cool[2], m_ptr[2], m_quiet[2];
  bit            m_tf[2];
  logic [AW-1:0] m_last[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int m);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m == 1) ? (m_ptr[m] + k) % N : k;
      if (c != 0 && req[c]) return c;
    end
    return -1;
  endfunction

  function automatic int bus_owner(input int m);
    if (m_pend[m] >= 0) return m_pend[m];
    if (m_own[m] >= 0)  return m_own[m];
    return 0;
  endfunction

  task automatic model_edge();
    int            o, w;
    bit            expire;
    logic [AW-1:0] a;
    for (int m = 0; m < 2; m++) begin
      o      = bus_owner(m);
      a      = addr[o*AW +: AW];
      expire = 1'b0;
      if (reset) begin
        m_own[m] = -1; m_pend[m] = -1; m_cool[m] = 0; m_ptr[m] = 0;
        m_quiet[m] = 0; m_tf[m] = 1'b0;
      end else if (m_pend[m] >= 0) begin
        m_own[m] = m_pend[m]; m_pend[m] = -1; m_quiet[m] = 0; m_tf[m] = 1'b0;
      end else if (m_own[m] >= 0) begin
`ifdef SRAM_ARB_TIMEOUT_EN
        expire = (m_quiet[m] == TO - 1);
        if (expire) m_tf[m] = 1'b1;
        m_quiet[m] = (!we_n[m_own[m]] || a != m_last[m]) ? 0 : m_quiet[m] + 1;
`endif
        if (done[m_own[m]] || expire) begin
          m_own[m] = -1; m_cool[m] = 1;
        end
      end else if (m_cool[m] > 0) begin
        m_cool[m]--;
      end else begin
        w = pick(m);
        if (w >= 0) begin
          m_pend[m] = w; m_ptr[m] = (w + 1) % N;
        end
      end
      m_last[m] = a;
    end
  endtask

  task automatic chk_inst(input string p, input int m, input logic [N-1:0] g,
                          input logic [1:0] ow, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic we, input logic b,
                          input logic tf);
    int o;
    o = bus_owner(m);
    chk({p, "_grant"}, 32'(g), (m_own[m] >= 0) ? 32'(1) << m_own[m] : 32'(0));
    chk({p, "_owner"}, 32'(ow), 32'(o));
    chk({p, "_addr"},  32'(a), 32'(addr[o*AW +: AW]));
    chk({p, "_data"},  32'(d), 32'(wdata[o*DW +: DW]));
    chk({p, "_we_n"},  32'(we), (m_pend[m] >= 0 || m_cool[m] > 0) ? 32'(1) : 32'(we_n[o]));
    chk({p, "_busy"},  32'(b), 32'(m_pend[m] >= 0 || m_own[m] >= 0 || m_cool[m] > 0));
    chk({p, "_tflag"}, 32'(tf), 32'(m_tf[m]));
  endtask

  // One clock: model consumes the inputs the DUT sampled, then outputs are compared.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk_inst("fp", 0, grant_f, owner_f, addr_f, data_f, wen_f, busy_f, tf_f);
    chk_inst("rr", 1, grant_r, owner_r, addr_r, data_r, wen_r, busy_r, tf_r);
  endtask

  task automatic wait_grant(input int m);
    int t;
    t = 0;
    while (m_own[m] < 0 && t < 12) begin
      cyc();
      t++;
    end
    chk("grant_wait", 32'(m_own[m] >= 0), 32'(1));
  endtask

  int exp_rr[4] = '{2, 4, 8, 2};
  int held;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_pend[m] = -1; m_cool[m] = 0; m_ptr[m] = 0;
      m_quiet[m] = 0; m_tf[m] = 1'b0; m_last[m] = '0;
    end
    reset = 1'b1; req = '0; done = '0; we_n = '1;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = AW'(32'h1000 * (i + 1));
      wdata[i*DW +: DW] = DW'(32'hA000 + i);
    end
    #2;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_addr", 32'(addr_f), 32'h1000);

    // Client 2 write: handover suppresses the write, grant follows a cycle later.
    addr[2*AW +: AW] = 18'h23F00;
    we_n[2] = 1'b0;
    req[2]  = 1'b1;
    cyc();
    chk("ho_we_n", 32'(wen_f), 32'(1));
    cyc();
    chk("own_grant", 32'(grant_f), 32'b0100);
    chk("own_addr", 32'(addr_f), 32'h23F00);
    chk("own_we_n", 32'(wen_f), 32'(0));
    req = '0;
    cyc(); cyc(); cyc();
    done = 4'b0100;
    cyc();
    done = '0;
    chk("rel_grant", 32'(grant_f), 32'(0));
    chk("rel_addr", 32'(addr_f), 32'h1000);
    cyc(); cyc();

    // Three requesters held: round-robin rotates, fixed priority keeps client 1.
    reset = 1'b1; cyc(); reset = 1'b0;
    we_n = '1;
    req  = 4'b1110;
    for (int n = 0; n < 4; n++) begin
      wait_grant(1);
      chk("rr_order", 32'(grant_r), 32'(exp_rr[n]));
      chk("fp_order", 32'(grant_f), 32'b0010);
      repeat (5) cyc();
      done = N'(1 << m_own[0]) | N'(1 << m_own[1]);
      cyc();
      done = '0;
    end

    // done from a non-owner is ignored.
    req = 4'b0010;
    wait_grant(0);
    done = 4'b1000;
    cyc();
    done = '0;
    chk("nonowner_done", 32'(grant_f), 32'b0010);
    cyc();
    chk("nonowner_done2", 32'(grant_f), 32'b0010);
    req  = '0;
    done = 4'b0010;
    cyc();
    done = '0;
    cyc(); cyc();

    // Silent owner: watchdog release (if built) or indefinite hold.
    req = 4'b0010;
    wait_grant(0);
    req  = '0;
    held = 0;
    while (grant_f != '0 && held < 40) begin
      cyc();
      held++;
    end
`ifdef SRAM_ARB_TIMEOUT_EN
    chk("wd_cycles", 32'(held), 32'(TO));
    chk("wd_flag", 32'(tf_f), 32'(1));
`else
    chk("hold_cycles", 32'(held), 32'(40));
    chk("hold_flag", 32'(tf_f), 32'(0));
    done = 4'b0010;
    cyc();
    done = '0;
`endif
    cyc(); cyc();

    // Reset while a client owns the bus.
    req = 4'b1000;
    wait_grant(0);
    req   = '0;
    reset = 1'b1;
    cyc();
    chk("midrst_grant", 32'(grant_f), 32'(0));
    chk("midrst_busy", 32'(busy_f), 32'(0));
    reset = 1'b0;
    cyc();

    // Randomised traffic against the model.
    repeat (600) begin
      reset = ($urandom_range(0, 63) == 0);
      req   = N'($urandom);
      done  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      we_n  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) addr[i*AW +: AW] = AW'($urandom);
        wdata[i*DW +: DW] = DW'($urandom);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Parametrised SRAM bus owner for the top level: multiplexes address, write data and write-enable from `NUM_CLIENTS` masters onto the single `SRAM_Controller` port. Client `DEFAULT_CLIENT` (the VGA reader) owns the bus whenever no grant is active. All other clients (UART loader, decompressor milestones, …) request the bus, receive exclusive ownership after a one-cycle handover, and release it with a `done` pulse. Fixed-priority or round-robin arbitration is selected by parameter, with an optional ownership watchdog.

## Interface
- `NUM_CLIENTS`, 4: number of masters, 2..8.
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `DEFAULT_CLIENT`, 0: index that owns the bus when idle.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `TIMEOUT_CYCLES`, 50_000_000: watchdog limit, used only with `SRAM_ARB_TIMEOUT_EN`.

- `CLOCK_50_I` input 1: clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input NUM_CLIENTS: level request per client; the `DEFAULT_CLIENT` bit is ignored.
- `done` input NUM_CLIENTS: one-cycle release pulse; honoured only from the current owner.
- `client_address` input NUM_CLIENTS*ADDR_W: packed, client i at `[i*ADDR_W +: ADDR_W]`.
- `client_write_data` input NUM_CLIENTS*DATA_W: packed, same layout.
- `client_we_n` input NUM_CLIENTS: active-low write enable per client.
- `grant` output NUM_CLIENTS: registered one-hot ownership; all zero when idle.
- `owner` output $clog2(NUM_CLIENTS): index currently driving the bus.
- `SRAM_address` output ADDR_W: muxed address.
- `SRAM_write_data` output DATA_W: muxed data.
- `SRAM_we_n` output 1: muxed write enable, forced 1 in turnaround states.
- `busy` output 1: high in any state other than S_ARB_IDLE.
- `timeout_flag` output 1: sticky forced-release indicator.

## Operation
- States:
  - S_ARB_IDLE: owner = DEFAULT_CLIENT, bus passes that client's signals unmodified.
  - S_ARB_HANDOVER: winner latched; mux selects winner's address and data; `SRAM_we_n` = 1.
  - S_ARB_OWNED: `grant[winner]` = 1; full passthrough of winner's signals.
  - S_ARB_RELEASE: mux returns to DEFAULT_CLIENT; `SRAM_we_n` = 1; `grant` = 0.
- Transitions: IDLE → HANDOVER when any non-default `req` is high. HANDOVER → OWNED unconditionally. OWNED → RELEASE on `done[owner]` (or watchdog expiry). RELEASE → IDLE unconditionally.
- Fixed priority: the lowest eligible index wins.
- Round-robin: search starts at (last winner + 1) mod NUM_CLIENTS; the pointer updates on entry to HANDOVER; the reset pointer is 0.
- Request dropped during HANDOVER/OWNED: the grant is kept; ownership ends only on `done` or timeout.
- `done` from a non-owner, or `done` outside OWNED: ignored.
- `done[owner]` together with another client's `req`: release first; the new request is arbitrated in IDLE after RELEASE.
- Reset mid-operation: returns to IDLE on the next edge, regardless of any in-flight write.
- Reset values: state S_ARB_IDLE, `grant` = 0, `owner` = DEFAULT_CLIENT, `busy` = 0, `timeout_flag` = 0, RR pointer = 0. The SRAM outputs are the combinational mux of DEFAULT_CLIENT.

## Timing
- `req` first sampled high at edge k:
  - HANDOVER during cycle k+1.
  - `grant` high from edge k+2.
  - The client's first write may be presented in cycle k+2.
- `done` sampled at edge j: `grant` low and bus back to default from edge j+1; IDLE at edge j+2.
- Minimum gap between two consecutive ownerships is 3 cycles: RELEASE, IDLE, HANDOVER.
- The mux path is combinational from the registered `owner`/state; there is no added latency on client data.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter runs in OWNED.
  - It clears on entry to OWNED, on any owner write (`we_n` = 0), or on any change of owner address.
  - On reaching TIMEOUT_CYCLES-1 the block forces OWNED → RELEASE and sets `timeout_flag`.
  - `timeout_flag` clears on the next entry to OWNED or on reset.
- Undefined: no counter is built, `timeout_flag` is tied 0, and ownership is held indefinitely.

## Structure
- `sram_arb_pkg`: `sram_arb_state_type` enum (the four states) and the index-width localparam function.
- Sub-module `sram_arb_picker`: combinational fixed/round-robin winner selection from `req`, the pointer and `RR_MODE`, producing a one-hot result and an index. The top holds the FSM, registers, mux and watchdog.

## Test plan
- Reset with `req` = 0: `grant` = 0, `owner` = 0, `SRAM_address` = client 0 address, `busy` = 0.
- `req[2]` raised at edge 10, client 2 drives addr 0x23F00 with `we_n` = 0:
  - `SRAM_we_n` = 1 in cycle 11.
  - `grant` = 0100 from edge 12, where `SRAM_address` = 0x23F00 and `SRAM_we_n` = 0.
  - `done[2]` pulse returns the bus to client 0 one cycle later.
- `RR_MODE` = 1 with `req[1]`, `req[2]`, `req[3]` held high and each owner pulsing `done` after 5 cycles: grant order is 1, 2, 3, 1.
- `RR_MODE` = 0 with the same stimulus: client 1 wins repeatedly.
- `done[3]` while client 1 owns: ignored, `grant` stays 0010.
- `SRAM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, owner idle: forced release exactly 16 cycles after OWNED entry and `timeout_flag` = 1. Reset asserted mid-OWNED: IDLE and `grant` = 0 next cycle.
